// File: rtl/if_pkg.sv
// Shared constants and types for the instruction fetch stage.
package if_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_JR
  } pc_sel_t;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: fixed-priority redirect encoder (jr > j > branch > sequential) and target mux.
module next_pc_mux
  import if_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jump_register,
  input  logic [31:0] jump_reg_target,
  output logic [31:0] next_pc,
  output logic        redirect
);

  pc_sel_t pc_sel;

  always_comb begin
    pc_sel = SEL_SEQ;
    if (jump_register) begin
      pc_sel = SEL_JR;
    end else if (jump) begin
      pc_sel = SEL_JUMP;
    end else if (branch) begin
      pc_sel = SEL_BRANCH;
    end
  end

  always_comb begin
    next_pc = pc + 32'd4;
    unique case (pc_sel)
      SEL_SEQ:    next_pc = pc + 32'd4;
      SEL_BRANCH: next_pc = branch_target;
      SEL_JUMP:   next_pc = jump_target;
      // Register data is an arbitrary word; keep the fetch address word aligned.
      SEL_JR:     next_pc = {jump_reg_target[31:2], 2'b00};
      default:    next_pc = pc + 32'd4;
    endcase
  end

  assign redirect = (pc_sel != SEL_SEQ);

endmodule

// File: rtl/instruction_fetch_stage.sv
// Pipeline front end: PC register, IF/ID register with stall/flush control, and perf counters.
module instruction_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PCWrite,
  input  logic             IF_IDWrite,
  input  logic             Branch,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic             JumpRegister,
  input  logic [31:0]      JumpRegTarget,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc_out,
  output logic             valid_out,
  output logic [31:0]      pc_current,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] seq_pc;

  assign seq_pc = pc_q + 32'd4;

  next_pc_mux u_next_pc_mux (
    .pc              (pc_q),
    .branch          (Branch),
    .branch_target   (BranchTarget),
    .jump            (Jump),
    .jump_target     (JumpTarget),
    .jump_register   (JumpRegister),
    .jump_reg_target (JumpRegTarget),
    .next_pc         (next_pc),
    .redirect        (redirect)
  );

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_plus4_d  = pc_plus4_q;
    valid_d     = valid_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!PCWrite) begin
      // Decode operands may be stale during a hazard stall, so redirects are ignored here.
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (IF_IDWrite) begin
        instr_d     = imem_rdata;
        pc_plus4_d  = seq_pc;
        valid_d     = 1'b1;
        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end
    end else if (redirect) begin
      pc_d        = next_pc;
      instr_d     = NOP_INSTR;
      pc_plus4_d  = 32'h0;
      valid_d     = 1'b0;
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      pc_d = next_pc;
      if (IF_IDWrite) begin
        instr_d     = imem_rdata;
        pc_plus4_d  = seq_pc;
        valid_d     = 1'b1;
        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc_plus4_q  <= 32'h0;
      valid_q     <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc_plus4_q  <= pc_plus4_d;
      valid_q     <= valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc_current  = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_plus4_q;
  assign valid_out   = valid_q;
  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed plus randomized bench for instruction_fetch_stage against a cycle-level reference model.
module tb_instruction_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Reset2 = 1'b0;
  logic        PCWrite, IF_IDWrite, Branch, Jump, JumpRegister;
  logic [31:0] BranchTarget, JumpTarget, JumpRegTarget;

  logic [31:0] imem_addr, imem_rdata, instr_out, pc_out, pc_current;
  logic [31:0] fetch_count, stall_count, flush_count;
  logic        valid_out;

  logic [31:0] imem_addr2, imem_rdata2, instr_out2, pc_out2, pc_current2;
  logic [31:0] fetch_count2, stall_count2, flush_count2;
  logic        valid_out2;

  int passed = 0;
  int total  = 0;

  // Reference model state: what the IF/ID register and counters should hold.
  logic [31:0] m_pc, m_instr, m_pcp4, m_fetch, m_stall, m_flush;
  logic        m_valid;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata  = imem_word(imem_addr);
  assign imem_rdata2 = imem_word(imem_addr2);

  instruction_fetch_stage dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .PCWrite       (PCWrite),
    .IF_IDWrite    (IF_IDWrite),
    .Branch        (Branch),
    .BranchTarget  (BranchTarget),
    .Jump          (Jump),
    .JumpTarget    (JumpTarget),
    .JumpRegister  (JumpRegister),
    .JumpRegTarget (JumpRegTarget),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .valid_out     (valid_out),
    .pc_current    (pc_current),
    .fetch_count   (fetch_count),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  instruction_fetch_stage #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .Clk           (Clk),
    .Reset         (Reset2),
    .PCWrite       (PCWrite),
    .IF_IDWrite    (IF_IDWrite),
    .Branch        (Branch),
    .BranchTarget  (BranchTarget),
    .Jump          (Jump),
    .JumpTarget    (JumpTarget),
    .JumpRegister  (JumpRegister),
    .JumpRegTarget (JumpRegTarget),
    .imem_addr     (imem_addr2),
    .imem_rdata    (imem_rdata2),
    .instr_out     (instr_out2),
    .pc_out        (pc_out2),
    .valid_out     (valid_out2),
    .pc_current    (pc_current2),
    .fetch_count   (fetch_count2),
    .stall_count   (stall_count2),
    .flush_count   (flush_count2)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset(input logic [31:0] rpc);
    m_pc = rpc; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
    m_fetch = 0; m_stall = 0; m_flush = 0;
  endtask

  // One rising edge worth of behaviour, from the current inputs and model state.
  task automatic model_edge();
    logic        redir;
    logic [31:0] tgt;
    redir = JumpRegister | Jump | Branch;
    tgt   = JumpRegister ? (JumpRegTarget & 32'hFFFF_FFFC) : (Jump ? JumpTarget : BranchTarget);
    if (!PCWrite) begin
      m_stall++;
      if (IF_IDWrite) begin
        m_instr = imem_word(m_pc); m_pcp4 = m_pc + 32'd4; m_valid = 1'b1; m_fetch++;
      end
    end else if (redir) begin
      m_pc = tgt; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_flush++;
    end else begin
      if (IF_IDWrite) begin
        m_instr = imem_word(m_pc); m_pcp4 = m_pc + 32'd4; m_valid = 1'b1; m_fetch++;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check32({tag, "/pc"},    pc_current, m_pc);
    check32({tag, "/addr"},  imem_addr,  m_pc);
    check32({tag, "/instr"}, instr_out,  m_instr);
    check32({tag, "/pcout"}, pc_out,     m_pcp4);
    check32({tag, "/valid"}, {31'b0, valid_out}, {31'b0, m_valid});
    check32({tag, "/fetch"}, fetch_count, m_fetch);
    check32({tag, "/stall"}, stall_count, m_stall);
    check32({tag, "/flush"}, flush_count, m_flush);
  endtask

  task automatic set_in(input logic pw, input logic iw,
                        input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic jr, input logic [31:0] jrt);
    PCWrite = pw; IF_IDWrite = iw;
    Branch = br; BranchTarget = bt;
    Jump = j; JumpTarget = jt;
    JumpRegister = jr; JumpRegTarget = jrt;
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    model_reset(32'h0);
    repeat (3) @(posedge Clk);
    #1;
    check_all("reset");

    // Release reset between edges; first edge captures imem[RESET_PC].
    Reset = 1'b1;
    step("edge1");
    check32("edge1_instr", instr_out, 32'h2008_0005);
    check32("edge1_pcout", pc_out, 32'h4);
    step("edge2");
    check32("edge2_instr", instr_out, 32'h2009_0003);
    check32("edge2_fetch", fetch_count, 32'd2);

    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("stall1");
    step("stall2");
    check32("stall_pc", pc_current, 32'h8);
    check32("stall_cnt", stall_count, 32'd2);
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    step("unstall");
    check32("unstall_instr", instr_out, imem_word(32'h8));

    set_in(1, 1, 1, 32'h40, 0, 0, 0, 0);
    step("branch");
    check32("branch_pc", pc_current, 32'h40);
    check32("branch_valid", {31'b0, valid_out}, 32'h0);
    check32("branch_flush", flush_count, 32'd1);
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    step("after_branch");
    check32("after_branch_pcout", pc_out, 32'h44);

    // Asynchronous reset between edges.
    #3;
    Reset = 1'b0;
    #1;
    model_reset(32'h0);
    check_all("async_rst");
    check32("async_rst_fetch", fetch_count, 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    check_all("rst_hold");
    Reset = 1'b1;

    set_in(1, 1, 1, 32'h40, 1, 32'h80, 1, 32'h103);
    step("priority");
    check32("priority_pc", pc_current, 32'h100);
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    step("after_prio");

    set_in(0, 0, 0, 0, 1, 32'h80, 0, 0);
    step("stall_redir");
    check32("stall_redir_pc", pc_current, 32'h104);
    check32("stall_redir_flush", flush_count, 32'd1);

    for (int i = 0; i < 400; i++) begin
      logic pw, iw;
      pw = ($urandom_range(0, 9) != 0);
      iw = pw ? ($urandom_range(0, 19) != 0) : $urandom_range(0, 1) == 1;
      set_in(pw, iw,
             $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 11) == 0, $urandom);
      step("rand");
      if (i == 200) begin
        #2;
        Reset = 1'b0;
        #1;
        model_reset(32'h0);
        check_all("rand_rst");
        #1;
        Reset = 1'b1;
      end
    end

    // Wrap-around from the top of the address space.
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    check32("wrap_rst_pc", pc_current2, 32'hFFFF_FFFC);
    check32("wrap_rst_valid", {31'b0, valid_out2}, 32'h0);
    Reset2 = 1'b1;
    @(posedge Clk);
    #1;
    check32("wrap_pcout", pc_out2, 32'h0);
    check32("wrap_pc", pc_current2, 32'h0);
    check32("wrap_instr", instr_out2, imem_word(32'hFFFF_FFFC));
    check32("wrap_valid", {31'b0, valid_out2}, 32'h1);
    check32("wrap_fetch", fetch_count2, 32'd1);
    check32("wrap_stall", stall_count2, 32'd0);
    check32("wrap_flush", flush_count2, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Front end of the 5-stage pipeline.
- Holds the PC, drives the instruction-memory address, and captures the fetched word plus PC+4 into the IF/ID pipeline register that feeds the decode stage.
- Takes redirects from decode (Branch/BranchTarget, Jump/JumpTarget, JumpRegister/rs data) and stall controls from the hazard detector (PCWrite, IF_IDWrite).
- Keeps fetch, stall and flush performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (low two bits must be 0).
- CNT_W, 32, width of each performance counter.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- PCWrite  in  1  1 = PC may update; 0 = hold PC.
- IF_IDWrite  in  1  1 = IF/ID may load; 0 = hold IF/ID.
- Branch  in  1  taken-branch redirect from decode.
- BranchTarget  in  32  branch target address.
- Jump  in  1  j/jal redirect.
- JumpTarget  in  32  jump target address.
- JumpRegister  in  1  jr redirect.
- JumpRegTarget  in  32  rs read data for jr.
- imem_addr  out  32  instruction memory address; combinational from PC register.
- imem_rdata  in  32  instruction word; combinational read of imem_addr.
- instr_out  out  32  IF/ID instruction.
- pc_out  out  32  IF/ID PC+4.
- valid_out  out  1  IF/ID holds a real, non-flushed instruction.
- pc_current  out  32  current PC, for debug/display.
- fetch_count  out  CNT_W  instructions loaded valid into IF/ID.
- stall_count  out  CNT_W  cycles with PCWrite=0.
- flush_count  out  CNT_W  redirects taken.

Behaviour:
- Reset low (async, any time, including mid-stall or mid-redirect):
  - PC = RESET_PC.
  - instr_out = 32'h0 (NOP), pc_out = 0, valid_out = 0.
  - All counters = 0.
- Reset release: the first rising edge captures imem_rdata at RESET_PC. After that edge: instr_out = imem[RESET_PC], pc_out = RESET_PC+4, valid_out = 1, PC = RESET_PC+4.
- Latency: one cycle from PC register to IF/ID.
- Redirect priority, highest first: JumpRegister, Jump, Branch, sequential PC+4.
- JR target: low two bits forced to 00. Branch and jump targets are used as given.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Edge action, in priority order:
  1. PCWrite=0: PC holds. IF/ID holds if IF_IDWrite=0, else loads as in the normal case. Redirect inputs are ignored this cycle, because decode operands may be stale during a hazard stall. stall_count += 1.
  2. PCWrite=1 and any redirect: PC = selected target. IF/ID is flushed regardless of IF_IDWrite: instr_out = NOP, pc_out = 0, valid_out = 0. The wrong-path word on imem_rdata is discarded. flush_count += 1.
  3. PCWrite=1, no redirect: PC = PC+4. If IF_IDWrite=1, IF/ID = {imem_rdata, PC+4}, valid_out = 1, fetch_count += 1. If IF_IDWrite=0, IF/ID holds (hazard unit never drives this combination; tolerated, not flagged).
- A redirect held for consecutive PCWrite=1 cycles is taken on each edge.
- Decode must drop Branch/Jump/JumpRegister once valid_out = 0.
- Counters wrap modulo 2^CNT_W.
- imem_addr = pc_current = PC register at all times; no extra registering.

Decomposition:
- Package if_pkg:
  - NOP_INSTR = 32'h0.
  - RESET_PC_DEFAULT.
  - Enum pc_sel_t {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JR}.
- Sub-module next_pc_mux: combinational priority encoder plus target mux producing next_pc and redirect.
- PC register, IF/ID register and counters stay in instruction_fetch_stage.

Test Plan:
- Reset sequencing: imem[0]=32'h2008_0005, imem[4]=32'h2009_0003; hold Reset low 3 cycles, release → edge 1: instr_out=32'h2008_0005, pc_out=4, valid_out=1; edge 2: instr_out=32'h2009_0003, pc_out=8, fetch_count=2.
- Stall: PCWrite=IF_IDWrite=0 for 2 cycles at PC=8 → PC stays 8, IF/ID unchanged, stall_count=2; release → next edge loads imem[8].
- Branch flush: at PC=12 assert Branch with BranchTarget=32'h40 → PC=32'h40, instr_out=0, valid_out=0, flush_count=1; next edge instr_out=imem[32'h40], pc_out=32'h44.
- Priority: Branch, Jump and JumpRegister all asserted with targets 32'h40, 32'h80, 32'h103 → PC=32'h100.
- Redirect during stall: PCWrite=0 with Jump=1, JumpTarget=32'h80 → PC unchanged, flush_count unchanged, stall_count += 1.
- Async reset mid-run: drop Reset between edges at PC=32'h44 → immediately PC=RESET_PC, valid_out=0, all counters 0; wrap check with RESET_PC=32'hFFFF_FFFC: after release, first edge gives pc_out=0 and PC=0.
